// File: rtl/ssc_pkg.sv
// Shared types and constants for the Super Serial Card serial helpers.
package ssc_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;

  localparam int SSC_CLKS_9600 = 1491;
  localparam int SSC_BYTE_W    = 8;
endpackage

// File: rtl/ssc_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; usable on either the RX or TX side of the card.
module ssc_byte_fifo
  import ssc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = SSC_BYTE_W
) (
  input  logic                   CLK_14M,
  input  logic                   RESET,
  input  logic                   push,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the head slot, so a push while full still lands.
  assign do_push = push & (~full | do_pop);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK_14M) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/ssc_rx_buffer.sv
// Host 8N1 receiver -> byte FIFO -> RTS-gated 8N1 re-transmitter into the 6551 UART_RXD pin.
// Build option SSC_RXBUF_STATS_EN adds the saturating DROP_COUNT statistics counter.
module ssc_rx_buffer
  import ssc_pkg::*;
#(
  parameter int CLKS_PER_BIT = SSC_CLKS_9600,
  parameter int DEPTH        = 16,
  parameter int HIGH_WATER   = 12,
  parameter int LOW_WATER    = 4
) (
  input  logic                   CLK_14M,
  input  logic                   RESET,
  input  logic                   HOST_RXD,
  output logic                   HOST_RTS_N,
  output logic                   SSC_RXD,
  input  logic                   SSC_RTS_N,
  output logic [$clog2(DEPTH):0] FIFO_LEVEL,
  output logic                   FRAME_ERR,
  output logic                   OVERRUN,
  input  logic                   OVERRUN_CLR,
  output logic [15:0]            DROP_COUNT
);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LVL_W-1:0] HW_LEVEL    = LVL_W'(HIGH_WATER);
  localparam logic [LVL_W-1:0] LW_LEVEL    = LVL_W'(LOW_WATER);

  logic       hsync_p0, hsync_p1, hline_p2;
  logic       rx_fall;
  ser_state_t rx_state, rx_state_nxt;
  logic [CW-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0] rx_bit, rx_bit_nxt;
  logic [7:0] rx_shift, rx_shift_nxt;
  logic       rx_push, rx_ferr;

  ser_state_t tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0] tx_bit, tx_bit_nxt;
  logic [7:0] tx_shift, tx_shift_nxt;
  logic       tx_line, tx_line_nxt;
  logic       tx_pop;

  logic [7:0] fifo_rd;
  logic       fifo_full, fifo_empty;
  logic       drop;

  // Stage p0/p1: two-flop synchroniser; p2: previous sample for edge detect
  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      hsync_p0 <= 1'b1;
      hsync_p1 <= 1'b1;
      hline_p2 <= 1'b1;
    end else begin
      hsync_p0 <= HOST_RXD;
      hsync_p1 <= hsync_p0;
      hline_p2 <= hsync_p1;
    end
  end

  assign rx_fall = hline_p2 & ~hsync_p1;

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_push      = 1'b0;
    rx_ferr      = 1'b0;
    case (rx_state)
      IDLE: begin
        if (rx_fall) begin
          rx_state_nxt = START;
          rx_cnt_nxt   = HALF_RELOAD;
        end
      end
      START: begin
        if (rx_cnt == '0) begin
          if (hsync_p1) begin
            rx_state_nxt = IDLE;
          end else begin
            rx_state_nxt = DATA;
            rx_cnt_nxt   = BIT_RELOAD;
            rx_bit_nxt   = '0;
          end
        end else begin
          rx_cnt_nxt = rx_cnt - 1'b1;
        end
      end
      DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_nxt = {hsync_p1, rx_shift[7:1]};
          rx_cnt_nxt   = BIT_RELOAD;
          rx_bit_nxt   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_nxt = STOP;
        end else begin
          rx_cnt_nxt = rx_cnt - 1'b1;
        end
      end
      STOP: begin
        if (rx_cnt == '0) begin
          rx_state_nxt = IDLE;
          rx_push      = hsync_p1;
          rx_ferr      = ~hsync_p1;
        end else begin
          rx_cnt_nxt = rx_cnt - 1'b1;
        end
      end
      default: rx_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
    end
  end

  always_ff @(posedge CLK_14M) rx_shift <= rx_shift_nxt;

  ssc_byte_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(SSC_BYTE_W)
  ) u_fifo (
    .CLK_14M(CLK_14M),
    .RESET  (RESET),
    .push   (rx_push),
    .wr_data(rx_shift),
    .pop    (tx_pop),
    .rd_data(fifo_rd),
    .level  (FIFO_LEVEL),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // The head is popped in the same cycle the frame starts; RTS only gates a new frame.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_line_nxt  = tx_line;
    tx_pop       = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_line_nxt = 1'b1;
        if (!fifo_empty && !SSC_RTS_N) begin
          tx_pop       = 1'b1;
          tx_shift_nxt = fifo_rd;
          tx_state_nxt = START;
          tx_cnt_nxt   = BIT_RELOAD;
          tx_line_nxt  = 1'b0;
        end
      end
      START: begin
        if (tx_cnt == '0) begin
          tx_state_nxt = DATA;
          tx_cnt_nxt   = BIT_RELOAD;
          tx_bit_nxt   = '0;
          tx_line_nxt  = tx_shift[0];
        end else begin
          tx_cnt_nxt = tx_cnt - 1'b1;
        end
      end
      DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_nxt = BIT_RELOAD;
          if (tx_bit == 3'd7) begin
            tx_state_nxt = STOP;
            tx_line_nxt  = 1'b1;
          end else begin
            tx_bit_nxt   = tx_bit + 3'd1;
            tx_shift_nxt = {1'b0, tx_shift[7:1]};
            tx_line_nxt  = tx_shift[1];
          end
        end else begin
          tx_cnt_nxt = tx_cnt - 1'b1;
        end
      end
      STOP: begin
        if (tx_cnt == '0) tx_state_nxt = IDLE;
        else              tx_cnt_nxt   = tx_cnt - 1'b1;
      end
      default: begin
        tx_state_nxt = IDLE;
        tx_line_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_line  <= tx_line_nxt;
    end
  end

  always_ff @(posedge CLK_14M) tx_shift <= tx_shift_nxt;

  assign SSC_RXD = tx_line;
  assign drop    = rx_push & fifo_full & ~tx_pop;

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      HOST_RTS_N <= 1'b0;
      FRAME_ERR  <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      FRAME_ERR <= rx_ferr;
      if (FIFO_LEVEL >= HW_LEVEL)      HOST_RTS_N <= 1'b1;
      else if (FIFO_LEVEL <= LW_LEVEL) HOST_RTS_N <= 1'b0;
      if (drop)             OVERRUN <= 1'b1;
      else if (OVERRUN_CLR) OVERRUN <= 1'b0;
    end
  end

`ifdef SSC_RXBUF_STATS_EN
  logic [15:0] drop_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge CLK_14M) begin
    if (RESET || OVERRUN_CLR)  drop_cnt <= '0;
    else if (drop || rx_ferr)  drop_cnt <= sat_inc16(drop_cnt);
  end

  assign DROP_COUNT = drop_cnt;
`else
  assign DROP_COUNT = 16'h0000;
`endif
endmodule

// File: tb/tb_ssc_rx_buffer.sv
// Randomised bench for ssc_rx_buffer against a queue-based model of the host->card byte stream.
module tb_ssc_rx_buffer;
  localparam int CPB   = 24;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB + 4;

`ifdef SSC_RXBUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK_14M = 1'b0;
  logic        RESET;
  logic        HOST_RXD;
  logic        HOST_RTS_N;
  logic        SSC_RXD;
  logic        SSC_RTS_N;
  logic [4:0]  FIFO_LEVEL;
  logic        FRAME_ERR;
  logic        OVERRUN;
  logic        OVERRUN_CLR;
  logic [15:0] DROP_COUNT;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] mdl_q[$];
  int         drop_exp = 0;
  logic       ovr_exp = 1'b0;
  int         tx_frames = 0;
  logic [7:0] last_tx = 8'h00;
  int         fe_pulses = 0;
  int         fe_cycles = 0;
  logic       fe_prev = 1'b0;
  int         n_push = 0;

  ssc_rx_buffer #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH),
    .HIGH_WATER  (12),
    .LOW_WATER   (4)
  ) dut (
    .CLK_14M    (CLK_14M),
    .RESET      (RESET),
    .HOST_RXD   (HOST_RXD),
    .HOST_RTS_N (HOST_RTS_N),
    .SSC_RXD    (SSC_RXD),
    .SSC_RTS_N  (SSC_RTS_N),
    .FIFO_LEVEL (FIFO_LEVEL),
    .FRAME_ERR  (FRAME_ERR),
    .OVERRUN    (OVERRUN),
    .OVERRUN_CLR(OVERRUN_CLR),
    .DROP_COUNT (DROP_COUNT)
  );

  always #5 CLK_14M = ~CLK_14M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_14M);
  endtask

  function automatic logic [31:0] drop_expected();
    return STATS ? 32'(drop_exp) : 32'd0;
  endfunction

  // Host-side 8N1 frame, started just after a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    HOST_RXD = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      HOST_RXD = b[i];
      cyc(CPB);
    end
    HOST_RXD = stop_ok;
    cyc(CPB);
    HOST_RXD = 1'b1;
  endtask

  task automatic model_rx(input logic [7:0] b, input logic ok);
    if (!ok) drop_exp++;
    else if (mdl_q.size() < DEPTH) mdl_q.push_back(b);
    else begin
      drop_exp++;
      ovr_exp = 1'b1;
    end
  endtask

  task automatic wait_frames(input string tag, input int target);
    int budget;
    budget = (target - tx_frames + 1) * FRAME;
    while (tx_frames < target && budget > 0) begin
      cyc(1);
      budget--;
    end
    chk(tag, tx_frames, target);
  endtask

  // Card-side decoder: checks each bit holds for exactly CPB cycles and compares against the model.
  initial begin : ssc_mon
    logic [9:0] bits;
    logic       first_b, last_b, aborted;
    bits = '0; first_b = 1'b0; last_b = 1'b0; aborted = 1'b0;
    forever begin
      @(negedge CLK_14M);
      if (RESET !== 1'b0 || SSC_RXD !== 1'b0) continue;
      aborted = 1'b0;
      for (int k = 0; k < 10; k++) begin
        for (int j = 0; j < CPB; j++) begin
          if (k != 0 || j != 0) @(negedge CLK_14M);
          if (RESET !== 1'b0) aborted = 1'b1;
          if (j == 0) first_b = SSC_RXD;
          if (j == CPB - 1) last_b = SSC_RXD;
        end
        if (aborted) break;
        chk("tx_bit_len", last_b, first_b);
        bits[k] = first_b;
      end
      if (!aborted) begin
        chk("tx_start_bit", bits[0], 1'b0);
        chk("tx_stop_bit", bits[9], 1'b1);
        last_tx = bits[8:1];
        if (mdl_q.size() == 0) chk("tx_frame_expected", mdl_q.size(), 1);
        else chk("tx_byte", bits[8:1], mdl_q.pop_front());
        tx_frames++;
      end
    end
  end

  initial begin : fe_mon
    forever begin
      @(negedge CLK_14M);
      if (FRAME_ERR === 1'b1) begin
        fe_cycles++;
        if (!fe_prev) fe_pulses++;
      end
      fe_prev = (FRAME_ERR === 1'b1);
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge CLK_14M);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] b;
    int         base, fe_p, fe_c, budget;
    logic       seen5;

    RESET = 1'b1; HOST_RXD = 1'b1; SSC_RTS_N = 1'b1; OVERRUN_CLR = 1'b0;
    cyc(4);
    chk("rst_ssc_rxd", SSC_RXD, 1'b1);
    chk("rst_host_rts", HOST_RTS_N, 1'b0);
    chk("rst_level", FIFO_LEVEL, 0);
    chk("rst_frame_err", FRAME_ERR, 1'b0);
    chk("rst_overrun", OVERRUN, 1'b0);
    chk("rst_drop", DROP_COUNT, 0);
    RESET = 1'b0;
    cyc(2);

    // 1: single byte into a blocked card; also measures where the push lands
    fork
      send_byte(8'h41, 1'b1);
      begin
        for (int n = 1; n <= 11 * CPB; n++) begin
          cyc(1);
          if (FIFO_LEVEL != 0 && n_push == 0) n_push = n;
        end
      end
    join
    model_rx(8'h41, 1'b1);
    chk("t1_push_latency", 32'((n_push >= 9 * CPB + CPB / 2) && (n_push <= 9 * CPB + CPB / 2 + 6)), 1);
    chk("t1_level", FIFO_LEVEL, 1);
    chk("t1_line_idle", SSC_RXD, 1'b1);
    chk("t1_no_frames", tx_frames, 0);

    // 2: enable the card
    SSC_RTS_N = 1'b0;
    cyc(3);
    chk("t2_level_after_pop", FIFO_LEVEL, 0);
    wait_frames("t2_frames", 1);
    chk("t2_byte", last_tx, 8'h41);
    cyc(2);
    SSC_RTS_N = 1'b1;

    // 3: high-water / low-water hysteresis
    base = tx_frames;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      model_rx(b, 1'b1);
      cyc(2);
      if (i == 10) chk("t3_rts_below_hw", HOST_RTS_N, 1'b0);
    end
    chk("t3_level_12", FIFO_LEVEL, 12);
    chk("t3_rts_at_hw", HOST_RTS_N, 1'b1);
    SSC_RTS_N = 1'b0;
    seen5 = 1'b0;
    budget = 12 * FRAME;
    while (FIFO_LEVEL > 4 && budget > 0) begin
      cyc(1);
      budget--;
      if (FIFO_LEVEL == 5 && !seen5) begin
        seen5 = 1'b1;
        chk("t3_rts_hold_5", HOST_RTS_N, 1'b1);
      end
    end
    chk("t3_reach_lw", 32'(FIFO_LEVEL <= 4), 1);
    cyc(1);
    chk("t3_rts_release", HOST_RTS_N, 1'b0);
    wait_frames("t3_frames", base + 12);
    cyc(2);
    chk("t3_drained", FIFO_LEVEL, 0);
    SSC_RTS_N = 1'b1;

    // 4: overrun with a blocked card
    base = tx_frames;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      model_rx(b, 1'b1);
      cyc(2);
    end
    chk("t4_level_full", FIFO_LEVEL, mdl_q.size());
    chk("t4_overrun", OVERRUN, ovr_exp);
    chk("t4_drop", DROP_COUNT, drop_expected());
    chk("t4_host_rts", HOST_RTS_N, 1'b1);
    OVERRUN_CLR = 1'b1;
    cyc(1);
    OVERRUN_CLR = 1'b0;
    ovr_exp = 1'b0;
    drop_exp = 0;
    cyc(1);
    chk("t4_overrun_clr", OVERRUN, ovr_exp);
    chk("t4_drop_clr", DROP_COUNT, drop_expected());
    SSC_RTS_N = 1'b0;
    wait_frames("t4_frames", base + 16);
    cyc(2);
    chk("t4_drained", FIFO_LEVEL, 0);
    SSC_RTS_N = 1'b1;

    // 5: framing error, then a short glitch, then a clean byte
    fe_p = fe_pulses;
    fe_c = fe_cycles;
    b = 8'($urandom);
    send_byte(b, 1'b0);
    model_rx(b, 1'b0);
    cyc(3);
    chk("t5_fe_pulses", fe_pulses - fe_p, 1);
    chk("t5_fe_width", fe_cycles - fe_c, 1);
    chk("t5_level", FIFO_LEVEL, 0);
    chk("t5_drop", DROP_COUNT, drop_expected());
    chk("t5_no_overrun", OVERRUN, ovr_exp);
    HOST_RXD = 1'b0;
    cyc(CPB / 2 - 4);
    HOST_RXD = 1'b1;
    cyc(3 * CPB);
    chk("t5_glitch_level", FIFO_LEVEL, 0);
    chk("t5_glitch_no_fe", fe_pulses - fe_p, 1);
    b = 8'($urandom);
    send_byte(b, 1'b1);
    model_rx(b, 1'b1);
    cyc(2);
    chk("t5_recover_level", FIFO_LEVEL, 1);

    // 6: push lands in the same cycle the transmitter pops
    base = tx_frames;
    b = 8'($urandom);
    fork
      send_byte(b, 1'b1);
      begin
        cyc(n_push - 1);
        chk("t6_level_pre", FIFO_LEVEL, 1);
        SSC_RTS_N = 1'b0;
        cyc(1);
        chk("t6_level_same", FIFO_LEVEL, 1);
        cyc(1);
        chk("t6_level_hold", FIFO_LEVEL, 1);
      end
    join
    model_rx(b, 1'b1);
    wait_frames("t6_frames", base + 2);
    cyc(2);
    chk("t6_drained", FIFO_LEVEL, 0);
    SSC_RTS_N = 1'b1;

    // 7: reset in the middle of a card-side frame
    send_byte(8'h00, 1'b1);
    model_rx(8'h00, 1'b1);
    cyc(2);
    b = 8'($urandom);
    send_byte(b, 1'b1);
    model_rx(b, 1'b1);
    cyc(2);
    chk("t7_level_2", FIFO_LEVEL, 2);
    SSC_RTS_N = 1'b0;
    cyc(4 * CPB);
    chk("t7_level_mid", FIFO_LEVEL, 1);
    chk("t7_line_low_mid", SSC_RXD, 1'b0);
    RESET = 1'b1;
    cyc(1);
    chk("t7_rst_line", SSC_RXD, 1'b1);
    chk("t7_rst_level", FIFO_LEVEL, 0);
    chk("t7_rst_host_rts", HOST_RTS_N, 1'b0);
    RESET = 1'b0;
    mdl_q.delete();
    drop_exp = 0;
    ovr_exp = 1'b0;
    base = tx_frames;
    cyc(30 * CPB);
    chk("t7_no_resend", tx_frames, base);
    chk("t7_line_idle", SSC_RXD, 1'b1);
    chk("t7_overrun", OVERRUN, ovr_exp);
    chk("t7_drop", DROP_COUNT, drop_expected());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
